stoch_div_mat_fb: RTL

Element-wise stochastic quotient Y = A ./ B over a NUM_ROWS x NUM_COLS matrix of unipolar bitstreams. Uses a feedback saturating-counter divider per element.
- One shared LFSR feeds every element, so area does not grow with one LFSR per element.
- Adds enable, synchronous clear, a warm-up phase and an output-valid flag.
- Sits in the stochastic matrix library as the drop-in successor for element-wise division in solver datapaths.

---
 rtl/stoch_div_pkg.sv | 80 ++++++++
 rtl/stoch_div_cell.sv | 54 +++++
 rtl/stoch_div_mat_fb.sv | 105 ++++++++++
 3 files changed

// File: rtl/stoch_div_pkg.sv
// Shared types and constants for the stochastic element-wise matrix divider.
// Holds the FSM encoding, the rotation stride and the maximal-length LFSR tap table.
package stoch_div_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} div_state_t;

  localparam int ROT_STRIDE = 3;

  function automatic logic [63:0] tap(input int t);
    return 64'd1 << (t - 1);
  endfunction

  // Fibonacci XOR tap masks (bit t-1 set for tap t); zero marks an unsupported width.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] m;
    m = '0;
    case (w)
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      33: m = tap(33) | tap(20);
      34: m = tap(34) | tap(27) | tap(2)  | tap(1);
      35: m = tap(35) | tap(33);
      36: m = tap(36) | tap(25);
      37: m = tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
      38: m = tap(38) | tap(6)  | tap(5)  | tap(1);
      39: m = tap(39) | tap(35);
      40: m = tap(40) | tap(38) | tap(21) | tap(19);
      41: m = tap(41) | tap(38);
      42: m = tap(42) | tap(41) | tap(20) | tap(19);
      43: m = tap(43) | tap(42) | tap(38) | tap(37);
      44: m = tap(44) | tap(43) | tap(18) | tap(17);
      45: m = tap(45) | tap(44) | tap(42) | tap(41);
      46: m = tap(46) | tap(45) | tap(26) | tap(25);
      47: m = tap(47) | tap(42);
      48: m = tap(48) | tap(47) | tap(21) | tap(20);
      49: m = tap(49) | tap(40);
      50: m = tap(50) | tap(49) | tap(24) | tap(23);
      51: m = tap(51) | tap(50) | tap(36) | tap(35);
      52: m = tap(52) | tap(49);
      53: m = tap(53) | tap(52) | tap(38) | tap(37);
      54: m = tap(54) | tap(53) | tap(18) | tap(17);
      55: m = tap(55) | tap(31);
      56: m = tap(56) | tap(55) | tap(35) | tap(34);
      57: m = tap(57) | tap(50);
      58: m = tap(58) | tap(39);
      59: m = tap(59) | tap(58) | tap(38) | tap(37);
      60: m = tap(60) | tap(59);
      61: m = tap(61) | tap(60) | tap(46) | tap(45);
      62: m = tap(62) | tap(61) | tap(6)  | tap(5);
      63: m = tap(63) | tap(62);
      64: m = tap(64) | tap(63) | tap(61) | tap(60);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stoch_div_cell.sv
// One matrix element: feedback saturating counter whose comparison against a
// random slice produces the quotient bitstream, plus the registered output bit.
module stoch_div_cell
  import stoch_div_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          a,
  input  logic          b,
  input  logic [CW-1:0] r,
  input  logic          step,
  input  logic          clr,
  input  logic          run,
  output logic          y
);

  localparam logic [CW-1:0] MID = {1'b1, {(CW-1){1'b0}}};

  // Result is never below -1 nor above 2^CW, so the two top bits identify both rails.
  function automatic logic [CW-1:0] sat_cnt(input logic signed [CW+1:0] v);
    if (v[CW+1]) return '0;
    if (v[CW])   return '1;
    return v[CW-1:0];
  endfunction

  logic [CW-1:0]        cnt;
  logic                 hit_p0;
  logic signed [CW+1:0] nxt_p0;

  // Stage 0: compare and net count change from registered counter and current LFSR.
  assign hit_p0 = cnt > r;
  assign nxt_p0 = $signed({2'b00, cnt})
                + $signed({{(CW+1){1'b0}}, a})
                - $signed({{(CW+1){1'b0}}, b & hit_p0});

  // Stage 1: counter state and registered quotient bit.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= MID;
    end else if (step) begin
      cnt <= sat_cnt(nxt_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      y <= 1'b0;
    end else begin
      y <= run & hit_p0;
    end
  end

endmodule

// File: rtl/stoch_div_mat_fb.sv
// Element-wise stochastic quotient Y = A ./ B over a matrix of unipolar bitstreams,
// sharing one Fibonacci LFSR across all elements via per-element rotations.
module stoch_div_mat_fb
  import stoch_div_pkg::*;
#(
  parameter int                    NUM_ROWS      = 2,
  parameter int                    NUM_COLS      = 2,
  parameter int                    COUNTER_WIDTH = 8,
  parameter int                    LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED     = 16'hACE1,
  parameter int                    WARMUP_CYCLES = 32
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               en,
  input  logic                               clear,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  A,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  B,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y,
  output logic                               valid
);

  localparam logic [63:0]           TAPS64 = lfsr_taps(LFSR_WIDTH);
  localparam logic [LFSR_WIDTH-1:0] TAPS   = TAPS64[LFSR_WIDTH-1:0];
  localparam int                    WCW    = $clog2(WARMUP_CYCLES + 2);
  localparam logic [WCW-1:0]        WLAST  = WCW'(WARMUP_CYCLES);

  if (LFSR_WIDTH < COUNTER_WIDTH) begin : g_chk_width
    $fatal(1, "LFSR_WIDTH must be >= COUNTER_WIDTH");
  end
  if (LFSR_SEED == '0) begin : g_chk_seed
    $fatal(1, "LFSR_SEED must be nonzero");
  end
  if (TAPS64 == 64'd0) begin : g_chk_taps
    $fatal(1, "LFSR_WIDTH must be in 8..64");
  end

  div_state_t                  state, state_n;
  logic [WCW-1:0]              wcnt, wcnt_n;
  logic [LFSR_WIDTH-1:0]       lfsr;
  logic [2*LFSR_WIDTH-1:0]     lfsr2;
  logic                        step, run, clr;

  assign clr   = !nRST || clear;
  assign step  = en && (state != IDLE);
  assign run   = en && (state == RUN);
  assign valid = (state == RUN);
  assign lfsr2 = {lfsr, lfsr};

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    if (clear) begin
      state_n = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
      wcnt_n  = '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          state_n = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
          wcnt_n  = '0;
        end
        WARMUP: begin
          wcnt_n = wcnt + 1'b1;
          if (wcnt_n == WLAST) state_n = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAPS)};
    end
  end

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
      localparam int ROT = (ROT_STRIDE * (i * NUM_COLS + j)) % LFSR_WIDTH;
      stoch_div_cell #(.CW(COUNTER_WIDTH)) u_cell (
        .clk  (CLK),
        .a    (A[i][j]),
        .b    (B[i][j]),
        .r    (lfsr2[ROT +: COUNTER_WIDTH]),
        .step (step),
        .clr  (clr),
        .run  (run),
        .y    (Y[i][j])
      );
    end
  end

endmodule
